// File: rtl/bcd_pkg.sv
// Shared BCD constants and state encoding.
// Used by both the BCD-to-binary and binary-to-BCD paths.
package bcd_pkg;

  localparam int BCD_DIGITS    = 4;
  localparam int BIN_WIDTH     = 16;
  localparam int SHIFT_COUNT   = 16;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int CNT_W         = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic logic digit_bad(
    input logic [3:0] d
  );
    return d > 4'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_nibble_sub3.sv
// Reverse double-dabble correction for one BCD nibble.
// Subtracts 3 from a nibble holding 8 or more.
module bcd_nibble_sub3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd8)
      o_nib = i_nib - 4'd3;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 16-bit binary converter.
// Reverse double-dabble, one shift per clock.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BIN_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       digit1,
  input  logic [3:0]       digit2,
  input  logic [3:0]       digit3,
  input  logic [3:0]       digit4,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_bcd;
  logic [WIDTH-1:0]     r_bin;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_value;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic [2*WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]     w_bcd_sh;
  logic [WIDTH-1:0]     w_bin_sh;
  logic [WIDTH-1:0]     w_bcd_corr;
  logic                 w_bad;
  logic                 w_last;

  assign w_bad = digit_bad(digit1) | digit_bad(digit2)
               | digit_bad(digit3) | digit_bad(digit4);

  assign w_shifted = {r_bcd, r_bin} >> 1;
  assign w_bcd_sh  = w_shifted[2*WIDTH-1:WIDTH];
  assign w_bin_sh  = w_shifted[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    bcd_nibble_sub3 u_sub3 (
      .i_nib (w_bcd_sh[4*g +: 4]),
      .o_nib (w_bcd_corr[4*g +: 4])
    );
  end

  assign w_last = (r_state == SHIFT)
               && (r_cnt == CNT_W'(SHIFT_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && !w_bad)
          w_next = SHIFT;
      end
      SHIFT: begin
        if (w_last)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_bcd <= {digit4, digit3, digit2, digit1};
            r_bin <= '0;
            r_cnt <= '0;
            if (w_bad) begin
              r_value <= '0;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_corr;
          r_bin <= w_bin_sh;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_value <= w_bin_sh;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign value = r_value;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin.
// Each task drives one scenario and checks inline.
module tb_bcd_to_bin;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic [3:0]  digit4;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        err;

  int nvec;
  int nfail;

  bcd_to_bin dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .digit4 (digit4),
    .value  (value),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_digits(
    input logic [3:0] d4,
    input logic [3:0] d3,
    input logic [3:0] d2,
    input logic [3:0] d1
  );
    digit4 = d4;
    digit3 = d3;
    digit2 = d2;
    digit1 = d1;
  endtask

  // Start is high across exactly one rising edge (edge k); returns at k+1ns.
  task automatic pulse_start(
    input logic [3:0] d4,
    input logic [3:0] d3,
    input logic [3:0] d2,
    input logic [3:0] d1
  );
    @(negedge clk);
    set_digits(d4, d3, d2, d1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({value, busy, done, err} !== 19'd0) begin
      nfail++;
      $display("FAIL reset_state: got v=%h b=%b d=%b e=%b want all 0",
               value, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_9999;
    int lat;
    int bcnt;
    pulse_start(4'd9, 4'd9, 4'd9, 4'd9);
    wait_done(lat, bcnt);
    nvec++;
    if (lat !== 16) begin
      nfail++;
      $display("FAIL 9999_latency: got %0d want 16", lat);
    end
    nvec++;
    if (bcnt !== 16) begin
      nfail++;
      $display("FAIL 9999_busy_cycles: got %0d want 16", bcnt);
    end
    nvec++;
    if (value !== 16'h270F || err !== 1'b0) begin
      nfail++;
      $display("FAIL 9999_value: got %h err=%b want 270f err=0",
               value, err);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done !== 1'b0 || value !== 16'h270F) begin
      nfail++;
      $display("FAIL 9999_done_width: done=%b v=%h want 0 270f",
               done, value);
    end
  endtask

  task automatic test_1234_and_0;
    int lat;
    int bcnt;
    pulse_start(4'd1, 4'd2, 4'd3, 4'd4);
    wait_done(lat, bcnt);
    nvec++;
    if (lat !== 16 || value !== 16'h04D2 || err !== 1'b0) begin
      nfail++;
      $display("FAIL 1234: lat=%0d v=%h e=%b want 16 04d2 0",
               lat, value, err);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done !== 1'b0) begin
      nfail++;
      $display("FAIL 1234_done_width: got %b want 0", done);
    end
    pulse_start(4'd0, 4'd0, 4'd0, 4'd0);
    wait_done(lat, bcnt);
    nvec++;
    if (lat !== 16 || value !== 16'h0000 || bcnt !== 16) begin
      nfail++;
      $display("FAIL zero: lat=%0d v=%h busy=%0d want 16 0000 16",
               lat, value, bcnt);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done !== 1'b0) begin
      nfail++;
      $display("FAIL zero_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_invalid;
    int lat;
    int bcnt;
    pulse_start(4'd0, 4'd0, 4'hA, 4'd0);
    nvec++;
    if (done !== 1'b1 || err !== 1'b1 || value !== 16'h0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL invalid: d=%b e=%b v=%h b=%b want 1 1 0000 0",
               done, err, value, busy);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL invalid_hold: d=%b e=%b b=%b want 0 1 0",
               done, err, busy);
    end
    pulse_start(4'd5, 4'd0, 4'd6, 4'd0);
    wait_done(lat, bcnt);
    nvec++;
    if (lat !== 16 || value !== 16'h13C4 || err !== 1'b0) begin
      nfail++;
      $display("FAIL 5060: lat=%0d v=%h e=%b want 16 13c4 0",
               lat, value, err);
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    int ndone;
    pulse_start(4'd1, 4'd2, 4'd3, 4'd4);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    nvec++;
    if (lat !== 16 || value !== 16'h04D2) begin
      nfail++;
      $display("FAIL busy_start: lat=%0d v=%h want 16 04d2", lat, value);
    end
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    nvec++;
    if (ndone !== 0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL busy_start_extra: dones=%0d busy=%b want 0 0",
               ndone, busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int bcnt;
    int ndone;
    pulse_start(4'd9, 4'd9, 4'd9, 4'd9);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if ({value, busy, done, err} !== 19'd0) begin
      nfail++;
      $display("FAIL reset_mid: v=%h b=%b d=%b e=%b want all 0",
               value, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    nvec++;
    if (ndone !== 0) begin
      nfail++;
      $display("FAIL reset_mid_quiet: active cycles=%0d want 0", ndone);
    end
    pulse_start(4'd0, 4'd0, 4'd4, 4'd2);
    wait_done(lat, bcnt);
    nvec++;
    if (lat !== 16 || value !== 16'h002A) begin
      nfail++;
      $display("FAIL 0042: lat=%0d v=%h want 16 002a", lat, value);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bcnt;
    pulse_start(4'd0, 4'd0, 4'd0, 4'd1);
    wait_done(lat, bcnt);
    nvec++;
    if (lat !== 16 || value !== 16'h0001) begin
      nfail++;
      $display("FAIL b2b_first: lat=%0d v=%h want 16 0001", lat, value);
    end
    set_digits(4'd0, 4'd1, 4'd0, 4'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    nvec++;
    if (lat + 1 !== 17 || value !== 16'h0064 || err !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_second: gap=%0d v=%h e=%b want 17 0064 0",
               lat + 1, value, err);
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    test_reset;
    test_9999;
    test_1234_and_0;
    test_invalid;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
